// File: rtl/recip_lut_arbiter.sv
// recip_lut_arbiter
//   Three requesters share one reciprocal unit computing floor(256/x) for 8-bit divisors.
//   A round-robin arbiter grants one requester at a time into a single-entry result register.
//   A zero divisor returns DIV_ZERO_VAL, flags rsp_div0 and bumps a saturating counter.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   req_valid  : per-requester valid, bit k = requester k
//   req_data   : divisors, requester k at [8k+7:8k]
//   req_ready  : one-hot grant; valid & ready = acceptance
//   rsp_valid  : result register holds a result
//   rsp_ready  : downstream takes the result this cycle
//   rsp_data   : floor(256/x), or DIV_ZERO_VAL for x = 0
//   rsp_id     : requester index owning rsp_data (0..2)
//   rsp_div0   : result came from a zero divisor
//   div0_count : saturating count of accepted zero divisors
module recip_lut_arbiter #(
   parameter logic [8:0] DIV_ZERO_VAL = 9'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req_valid,
   input  logic [23:0] req_data,
   output logic [2:0]  req_ready,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [8:0]  rsp_data,
   output logic [1:0]  rsp_id,
   output logic        rsp_div0,
   output logic [7:0]  div0_count
);

   typedef enum logic [0:0] {StEmpty, StFull} state_e;

   state_e      state_q, state_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [8:0]  data_q, data_d;
   logic [1:0]  id_q, id_d;
   logic        div0_q, div0_d;
   logic [7:0]  cnt_q, cnt_d;

   logic [2:0]  gnt;
   logic [1:0]  gnt_id;
   logic        gnt_any;
   logic [1:0]  idx;
   logic        slot_free;
   logic        accept;
   logic [7:0]  sel_div;

   // Restoring division of the constant 256 by x; the remainder never exceeds 8 bits.
   function automatic logic [8:0] recip(input logic [7:0] x);
      logic [8:0] rem;
      logic [8:0] q;
      logic [8:0] n;
      n   = 9'd256;
      rem = 9'd0;
      q   = 9'd0;
      for (int i = 8; i >= 0; i--) begin
         rem = {rem[7:0], n[i]};
         if (rem >= {1'b0, x}) begin
            rem  = rem - {1'b0, x};
            q[i] = 1'b1;
         end
      end
      return q;
   endfunction

   // Round-robin search starting at ptr_q, wrapping modulo 3.
   always_comb begin
      gnt     = 3'b000;
      gnt_id  = 2'd0;
      gnt_any = 1'b0;
      idx     = ptr_q;
      for (int i = 0; i < 3; i++) begin
         if (!gnt_any && req_valid[idx]) begin
            gnt[idx] = 1'b1;
            gnt_id   = idx;
            gnt_any  = 1'b1;
         end
         idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end
   end

   always_comb begin
      sel_div = 8'd0;
      case (gnt_id)
         2'd0:    sel_div = req_data[7:0];
         2'd1:    sel_div = req_data[15:8];
         2'd2:    sel_div = req_data[23:16];
         default: sel_div = 8'd0;
      endcase
   end

   // A full slot is free when it drains this cycle; reset blocks all grants.
   assign slot_free = !rst && ((state_q == StEmpty) || rsp_ready);
   assign req_ready = slot_free ? gnt : 3'b000;
   assign accept    = slot_free && gnt_any;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      id_d    = id_q;
      div0_d  = div0_q;
      cnt_d   = cnt_q;
      if (accept) begin
         state_d = StFull;
         ptr_d   = (gnt_id == 2'd2) ? 2'd0 : gnt_id + 2'd1;
         id_d    = gnt_id;
         div0_d  = (sel_div == 8'd0);
         data_d  = (sel_div == 8'd0) ? DIV_ZERO_VAL : recip(sel_div);
         if ((sel_div == 8'd0) && (cnt_q != 8'hff)) begin
            cnt_d = cnt_q + 8'd1;
         end
      end else if ((state_q == StFull) && rsp_ready) begin
         state_d = StEmpty;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StEmpty;
         ptr_q   <= 2'd0;
         data_q  <= 9'd0;
         id_q    <= 2'd0;
         div0_q  <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         id_q    <= id_d;
         div0_q  <= div0_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rsp_valid  = (state_q == StFull);
   assign rsp_data   = data_q;
   assign rsp_id     = id_q;
   assign rsp_div0   = div0_q;
   assign div0_count = cnt_q;

endmodule

// File: doc/recip_lut_arbiter.md
RECIP_LUT_ARBITER -- requirements
Module: recip_lut_arbiter

Interface
REQ-001 Parameter: DIV_ZERO_VAL, default 9'd0, result returned for a zero divisor.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req_valid  input  3  per-requester divisor valid, bit k = requester k.
REQ-005 Port: req_data  input  24  divisors, requester k at bits [8k+7:8k].
REQ-006 Port: req_ready  output  3  one-hot grant; acceptance of k = req_valid[k] & req_ready[k].
REQ-007 Port: rsp_valid  output  1  result register holds a valid result.
REQ-008 Port: rsp_ready  input  1  downstream accepts the result this cycle.
REQ-009 Port: rsp_data  output  9  reciprocal result, floor(256/x).
REQ-010 Port: rsp_id  output  2  index (0..2) of the requester that owns rsp_data.
REQ-011 Port: rsp_div0  output  1  result came from a zero divisor.
REQ-012 Port: div0_count  output  8  saturating count of accepted zero divisors.

Function
REQ-013 The block shall share one reciprocal lookup among three requesters: x=1..255 -> floor(256/x) (1->256, 3->85, 7->36, 128->2, 129..255->1); x=0 -> DIV_ZERO_VAL with rsp_div0=1.
REQ-014 The block shall have two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-015 Slot free = EMPTY, or FULL with rsp_ready=1 in the same cycle.
REQ-016 When the slot is free and any req_valid is set, exactly one req_ready bit shall assert, combinationally, for the granted requester; otherwise req_ready=3'b000.
REQ-017 Grant shall be round-robin: search starts at pointer p (reset 0) and proceeds p, p+1, p+2 mod 3; the first requester with req_valid set wins.
REQ-018 On acceptance of requester k, p shall become (k+1) mod 3; p shall not change on a cycle without acceptance.
REQ-019 An acceptance in cycle N shall load rsp_data/rsp_id/rsp_div0 and show rsp_valid=1 in cycle N+1 (latency 1).
REQ-020 Throughput: FULL with rsp_ready=1 and a pending request shall drain and reload in the same cycle, giving one result per cycle sustained.
REQ-021 FULL with rsp_ready=0: rsp_valid, rsp_data, rsp_id and rsp_div0 shall stay stable and req_ready=3'b000.
REQ-022 FULL with rsp_ready=1 and no request: transition to EMPTY. rsp_data, rsp_id and rsp_div0 shall keep their last values.
REQ-023 Each requester shall hold req_valid and req_data stable until accepted. The block shall sample req_data only at acceptance.
REQ-024 With all three requesters continuously valid and rsp_ready=1, grants shall cycle 0,1,2,0,... with no requester waiting more than two grants.
REQ-025 div0_count shall increment by 1 on each accepted zero divisor and saturate at 255 (no wrap).
REQ-026 rsp_id shall never take value 3.

Reset
REQ-027 When rst=1 at a clock edge: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_div0=0, div0_count=0, p=0, state=EMPTY.
REQ-028 During a cycle with rst=1, req_ready shall be 3'b000, and no request shall be accepted.
REQ-029 Reset mid-operation shall discard any held result without emitting it. rst overrides simultaneous acceptance or drain.

Verification
REQ-030 Single request: req_valid=3'b010, req_data[15:8]=7, rsp_ready=1 -> req_ready=3'b010 in cycle N; cycle N+1: rsp_valid=1, rsp_data=36, rsp_id=1, rsp_div0=0.
REQ-031 Fairness: all requesters valid with divisors 1, 3, 255, rsp_ready=1 for 6 cycles -> rsp_id sequence 0,1,2,0,1,2 and rsp_data 256,85,1,256,85,1 on consecutive cycles.
REQ-032 Backpressure: produce a result, hold rsp_ready=0 for 4 cycles with all req_valid set -> outputs frozen, req_ready=0. Then raise rsp_ready -> drain and new grant in the same cycle, no gap.
REQ-033 Divide-by-zero: 300 accepted zero divisors -> each rsp_data=DIV_ZERO_VAL and rsp_div0=1; div0_count=255 after the 255th, stays 255.
REQ-034 Reset mid-operation: FULL with rsp_ready=0, assert rst one cycle -> next cycle rsp_valid=0, all outputs 0, p=0. With all three valid afterwards, requester 0 is granted first.
REQ-035 Boundary divisors: 128 -> 2, 129 -> 1, 64 -> 4, 65 -> 3, 1 -> 256. Every result carries the correct rsp_id.
